rf_scb: RTL and testbench

//  Parametrised successor to the 8x8 2-read/1-write CPU register file.
//  - Adds generic width, depth and read-port count.
//  - Adds a per-register busy scoreboard for in-flight producers.
//  - Adds a sequenced bulk-clear engine.
//  - Sits between decode (reads, scoreboard set) and writeback (write, busy clear).

---
 rtl/rf_pkg.sv | 12 +
 rtl/rf_clr_fsm.sv | 75 +++++++
 rtl/rf_scb.sv | 100 ++++++++++
 tb/tb_rf_scb.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared defaults and types for the scoreboarded register file
// Purpose: default geometry and the bulk-clear FSM state encoding.
// Ports:   none (package).
package rf_pkg;

   localparam int RF_DATA_W   = 8;
   localparam int RF_NUM_REGS = 8;
   localparam int RF_NUM_RD   = 2;

   typedef enum logic [0:0] {RF_IDLE, RF_CLEAR} rf_clr_state_t;

endpackage

// File: rtl/rf_clr_fsm.sv
// rtl/rf_clr_fsm.sv - sequenced bulk-clear engine for the register file
// Purpose: walks indices 1..NUM_REGS-1, issuing one zeroing write per cycle.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   clr_req         start a bulk clear (sampled only in IDLE)
//   idle            FSM is in IDLE (array may accept writes/sets)
//   clr_start       IDLE->CLEAR transition this cycle (busy bits wiped at edge)
//   clr_wr_en       zeroing write to clr_wr_addr this cycle
//   clr_wr_addr     index being zeroed
//   clr_busy        registered, high while in CLEAR
module rf_clr_fsm
   import rf_pkg::*;
#(
   parameter int NUM_REGS = RF_NUM_REGS,
   parameter int AW       = $clog2(NUM_REGS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_req,
   output logic          idle,
   output logic          clr_start,
   output logic          clr_wr_en,
   output logic [AW-1:0] clr_wr_addr,
   output logic          clr_busy
);

   localparam logic [AW-1:0] LAST = AW'(NUM_REGS - 1);

   rf_clr_state_t state, state_nxt;
   logic [AW-1:0] cnt, cnt_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= RF_IDLE;
         cnt      <= '0;
         clr_busy <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         // Registered copy of the next state so clr_busy rises on the
         // same edge that samples clr_req.
         clr_busy <= (state_nxt == RF_CLEAR);
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      clr_start   = 1'b0;
      clr_wr_en   = 1'b0;
      clr_wr_addr = cnt;
      case (state)
         RF_IDLE: begin
            if (clr_req) begin
               state_nxt = RF_CLEAR;
               cnt_nxt   = AW'(1);   // index 0 is hardwired, never cleared
               clr_start = 1'b1;
            end
         end
         RF_CLEAR: begin
            clr_wr_en = 1'b1;
            if (cnt == LAST) begin
               state_nxt = RF_IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + AW'(1);
            end
         end
         default: state_nxt = RF_IDLE;
      endcase
   end

   assign idle = (state == RF_IDLE);

endmodule

// File: rtl/rf_scb.sv
// rtl/rf_scb.sv - multi-port register file with busy scoreboard and bulk clear
// Purpose: register array, per-register busy bits and combinational read ports.
//   Optional macro RF_BYPASS_EN forwards a same-cycle writeback to readers.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   w_en, w_addr, w_data     writeback (also clears busy of w_addr)
//   r_addr, r_data, r_busy   NUM_RD packed read ports (port k at slice k)
//   sb_set_en, sb_set_addr   mark a register busy (producer issued)
//   clr_req, clr_busy        bulk clear request / in progress
module rf_scb
   import rf_pkg::*;
#(
   parameter int DATA_W   = RF_DATA_W,
   parameter int NUM_REGS = RF_NUM_REGS,
   parameter int NUM_RD   = RF_NUM_RD,
   parameter int AW       = $clog2(NUM_REGS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     w_en,
   input  logic [AW-1:0]            w_addr,
   input  logic [DATA_W-1:0]        w_data,
   input  logic [NUM_RD*AW-1:0]     r_addr,
   output logic [NUM_RD*DATA_W-1:0] r_data,
   output logic [NUM_RD-1:0]        r_busy,
   input  logic                     sb_set_en,
   input  logic [AW-1:0]            sb_set_addr,
   input  logic                     clr_req,
   output logic                     clr_busy
);

   logic [DATA_W-1:0]   regs [NUM_REGS];
   logic [NUM_REGS-1:0] busy;

   logic          idle;
   logic          clr_start;
   logic          clr_wr_en;
   logic [AW-1:0] clr_wr_addr;
   logic          we;
   logic          se;

   rf_clr_fsm #(
      .NUM_REGS (NUM_REGS),
      .AW       (AW)
   ) u_clr_fsm (
      .clk         (clk),
      .rst         (rst),
      .clr_req     (clr_req),
      .idle        (idle),
      .clr_start   (clr_start),
      .clr_wr_en   (clr_wr_en),
      .clr_wr_addr (clr_wr_addr),
      .clr_busy    (clr_busy)
   );

   // A clear starting this cycle takes priority over writeback and set.
   assign we = w_en      && (w_addr      != '0) && idle && !clr_start;
   assign se = sb_set_en && (sb_set_addr != '0) && idle && !clr_start;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
         busy <= '0;
      end else begin
         if (clr_wr_en) regs[clr_wr_addr] <= '0;
         if (we)        regs[w_addr]      <= w_data;
         if (clr_start) busy <= '0;
         if (we)        busy[w_addr]      <= 1'b0;
         // Later assignment wins: a new producer outranks a same-index writeback.
         if (se)        busy[sb_set_addr] <= 1'b1;
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [AW-1:0]     ra;
      logic [DATA_W-1:0] rd;
      logic              rb;

      assign ra = r_addr[k*AW +: AW];

      always_comb begin
         rd = regs[ra];
         rb = busy[ra];
`ifdef RF_BYPASS_EN
         if (we && (ra == w_addr)) begin
            rd = w_data;
            rb = se && (sb_set_addr == ra);
         end
`endif
         if (ra == '0) begin
            rd = '0;
            rb = 1'b0;
         end
      end

      assign r_data[k*DATA_W +: DATA_W] = rd;
      assign r_busy[k]                  = rb;
   end

endmodule

// File: tb/tb_rf_scb.sv
// tb/tb_rf_scb.sv - directed and model-checked bench for rf_scb
module tb_rf_scb;

   logic        clk;
   logic        rst;
   logic        w_en;
   logic [2:0]  w_addr;
   logic [7:0]  w_data;
   logic [5:0]  r_addr;
   logic [15:0] r_data;
   logic [1:0]  r_busy;
   logic        sb_set_en;
   logic [2:0]  sb_set_addr;
   logic        clr_req;
   logic        clr_busy;

   int errors = 0;
   int checks = 0;

   rf_scb dut (
      .clk         (clk),
      .rst         (rst),
      .w_en        (w_en),
      .w_addr      (w_addr),
      .w_data      (w_data),
      .r_addr      (r_addr),
      .r_data      (r_data),
      .r_busy      (r_busy),
      .sb_set_en   (sb_set_en),
      .sb_set_addr (sb_set_addr),
      .clr_req     (clr_req),
      .clr_busy    (clr_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [2:0] a0, input logic [2:0] a1);
      r_addr = {a1, a0};
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      w_en = 1'b1; w_addr = a; w_data = d;
      tick();
      w_en = 1'b0;
   endtask

   logic [7:0] m_regs [8];
   logic [7:0] m_busy;
   logic       m_clr;
   int         m_cnt;
   int         n;

   initial begin
      rst = 1'b1; w_en = 1'b0; w_addr = '0; w_data = '0; r_addr = '0;
      sb_set_en = 1'b0; sb_set_addr = '0; clr_req = 1'b0;
      tick();
      rst = 1'b0;

      // 1: reset state
      chk("reset_clr_busy", clr_busy, 0);
      for (int i = 0; i < 8; i++) begin
         rd(3'(i), 3'(7 - i));
         chk("reset_data0", r_data[7:0], 0);
         chk("reset_data1", r_data[15:8], 0);
         chk("reset_busy", r_busy, 0);
      end

      // 2: basic write, index 0 dropped
      wr(3, 8'hA5);
      rd(3, 0);
      chk("wr_r3", r_data[7:0], 8'hA5);
      wr(0, 8'hFF);
      rd(0, 3);
      chk("wr_r0_dropped", r_data[7:0], 0);
      chk("r0_busy", r_busy[0], 0);
      chk("r3_port1", r_data[15:8], 8'hA5);

      // 3: scoreboard
      sb_set_en = 1'b1; sb_set_addr = 5; tick(); sb_set_en = 1'b0;
      rd(0, 5);
      chk("sb_r5_busy", r_busy[1], 1);
      wr(5, 8'h3C);
      rd(5, 5);
      chk("r5_data", r_data[7:0], 8'h3C);
      chk("r5_busy_clr", r_busy, 2'b00);
      sb_set_en = 1'b1; sb_set_addr = 5; w_en = 1'b1; w_addr = 5; w_data = 8'h3C;
      tick();
      sb_set_en = 1'b0; w_en = 1'b0;
      rd(5, 0);
      chk("same_idx_data", r_data[7:0], 8'h3C);
      chk("same_idx_busy", r_busy[0], 1);
      sb_set_en = 1'b1; sb_set_addr = 6; w_en = 1'b1; w_addr = 7; w_data = 8'h99;
      tick();
      sb_set_en = 1'b0; w_en = 1'b0;
      rd(6, 7);
      chk("diff_idx_busy", r_busy, 2'b01);
      chk("diff_idx_data", r_data[15:8], 8'h99);

      // 6: same-cycle read of a writeback (r6 is 0 and busy)
      w_en = 1'b1; w_addr = 6; w_data = 8'h5A;
      rd(6, 0);
`ifdef RF_BYPASS_EN
      chk("bypass_data", r_data[7:0], 8'h5A);
      chk("bypass_busy", r_busy[0], 0);
`else
      chk("nobypass_data", r_data[7:0], 8'h00);
      chk("nobypass_busy", r_busy[0], 1);
`endif
      tick();
      w_en = 1'b0;
      rd(6, 0);
      chk("after_wr_r6", r_data[7:0], 8'h5A);
      chk("after_wr_r6_busy", r_busy[0], 0);

      // 4: bulk clear
      for (int i = 1; i < 8; i++) wr(3'(i), 8'(i * 8'h11));
      sb_set_en = 1'b1; sb_set_addr = 2; tick(); sb_set_en = 1'b0;
      rd(7, 2);
      chk("fill_r7", r_data[7:0], 8'h77);
      chk("fill_r2_busy", r_busy[1], 1);
      // coincident write to r4 loses to the clear
      clr_req = 1'b1; w_en = 1'b1; w_addr = 4; w_data = 8'hEE;
      tick();
      clr_req = 1'b0; w_en = 1'b0;
      n = 0;
      while (clr_busy === 1'b1 && n < 20) begin
         n++;
         if (n == 3) begin
            rd(1, 3);
            chk("mid_clear_r1", r_data[7:0], 0);
            chk("mid_clear_r3", r_data[15:8], 8'h33);
            rd(2, 0);
            chk("mid_clear_r2_busy", r_busy[0], 0);
         end
         // after r4 was zeroed; must not land
         w_en = (n == 6); w_addr = 4; w_data = 8'hEE;
         sb_set_en = (n == 6); sb_set_addr = 4;
         tick();
         w_en = 1'b0; sb_set_en = 1'b0;
      end
      chk("clear_cycles", n, 7);
      for (int i = 0; i < 8; i++) begin
         rd(3'(i), 3'(i));
         chk("post_clear_data", r_data, 0);
         chk("post_clear_busy", r_busy, 0);
      end

      // 5: reset during clear
      wr(7, 8'h77);
      clr_req = 1'b1; tick(); clr_req = 1'b0;
      tick(); tick();
      rst = 1'b1; tick(); rst = 1'b0;
      chk("rst_abort_clr_busy", clr_busy, 0);
      for (int i = 0; i < 8; i++) begin
         rd(3'(i), 3'(i));
         chk("rst_abort_data", r_data, 0);
      end
      wr(2, 8'h42);
      rd(2, 0);
      chk("fresh_write", r_data[7:0], 8'h42);

      // 7: random traffic against a reference model
      rst = 1'b1; tick(); rst = 1'b0;
      for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
      m_busy = 8'h00; m_clr = 1'b0; m_cnt = 0;
      for (int cyc = 0; cyc < 1000; cyc++) begin
         logic ok_w, ok_s;
         logic [2:0] ra [2];
         logic [7:0] ed;
         logic       eb;
         w_en        = 1'($urandom_range(0, 1));
         w_addr      = 3'($urandom_range(0, 7));
         w_data      = 8'($urandom);
         sb_set_en   = ($urandom_range(0, 3) == 0);
         sb_set_addr = 3'($urandom_range(0, 7));
         clr_req     = ((cyc % 97) == 50) || ($urandom_range(0, 199) == 0);
         ra[0]       = 3'($urandom_range(0, 7));
         ra[1]       = ($urandom_range(0, 2) == 0) ? w_addr : 3'($urandom_range(0, 7));
         rd(ra[0], ra[1]);
         ok_w = !m_clr && !clr_req && w_en && (w_addr != 0);
         ok_s = !m_clr && !clr_req && sb_set_en && (sb_set_addr != 0);
         chk("rand_clr_busy", clr_busy, m_clr);
         for (int k = 0; k < 2; k++) begin
            ed = m_regs[ra[k]];
            eb = m_busy[ra[k]];
`ifdef RF_BYPASS_EN
            if (ok_w && ra[k] == w_addr) begin
               ed = w_data;
               eb = ok_s && (sb_set_addr == ra[k]);
            end
`endif
            if (ra[k] == 0) begin
               ed = 8'h00;
               eb = 1'b0;
            end
            chk("rand_data", r_data[k*8 +: 8], ed);
            chk("rand_busy", r_busy[k], eb);
         end
         if (m_clr) begin
            m_regs[m_cnt] = 8'h00;
            if (m_cnt == 7) m_clr = 1'b0;
            else m_cnt++;
         end else if (clr_req) begin
            m_clr = 1'b1;
            m_cnt = 1;
            m_busy = 8'h00;
         end else begin
            if (ok_w) begin
               m_regs[w_addr] = w_data;
               m_busy[w_addr] = 1'b0;
            end
            if (ok_s) m_busy[sb_set_addr] = 1'b1;
         end
         tick();
      end
      w_en = 1'b0; sb_set_en = 1'b0; clr_req = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
